// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: states, opcodes,
// IR field positions and opcode class helpers.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    RST,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    HALTED
  } ctrl_state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_AND      = 5'b00000;
  localparam logic [4:0] OP_OR       = 5'b00001;
  localparam logic [4:0] OP_ADD      = 5'b00010;
  localparam logic [4:0] OP_SUB      = 5'b00011;
  localparam logic [4:0] OP_SHR      = 5'b00100;
  localparam logic [4:0] OP_SHRA     = 5'b00101;
  localparam logic [4:0] OP_SHL      = 5'b00110;
  localparam logic [4:0] OP_ROR      = 5'b00111;
  localparam logic [4:0] OP_ROL      = 5'b01000;
  localparam logic [4:0] OP_NEG      = 5'b01001;
  localparam logic [4:0] OP_NOT      = 5'b01010;
  localparam logic [4:0] OP_ALU_LAST = 5'b01011;
  localparam logic [4:0] OP_MUL      = 5'b01111;
  localparam logic [4:0] OP_DIV      = 5'b10000;
  localparam logic [4:0] OP_NOP      = 5'b11010;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  function automatic logic is_alu(input logic [4:0] op);
    return op <= OP_ALU_LAST;
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Turns a 4-bit register number into a 16-bit one-hot select, gated by en.
module reg_onehot_dec (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch T0-T2 and execute T3-T6 and emits
// the single-bus datapath strobes, counting retired instructions.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  input  logic             Stop,
  input  logic             Start,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic [4:0]       operation,
  output logic             Run,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  ctrl_state_t state;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       op_alu, op_muldiv, op_exec, op_nop, op_halt;
  logic       unused_ir_bits;

  assign opc       = IR[OPC_MSB:OPC_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign op_alu    = is_alu(opc);
  assign op_muldiv = is_muldiv(opc);
  assign op_exec   = op_alu || op_muldiv;
  assign op_nop    = (opc == OP_NOP);
  assign op_halt   = (opc == OP_HALT);
  assign unused_ir_bits = ^IR[RC_LSB-1:0];

  // Every path back to T0 samples Stop; HALT and Start bypass that check.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= RST;
      instr_count <= '0;
    end else begin
      case (state)
        RST: state <= T0;
        T0:  state <= T1;
        T1:  if (mem_ready) state <= T2;
        T2:  state <= T3;
        T3: begin
          if (op_exec) begin
            state <= T4;
          end else begin
            instr_count <= instr_count + CNT_W'(1);
            if (op_halt) state <= HALTED;
            else         state <= Stop ? HALTED : T0;
          end
        end
        T4: state <= T5;
        T5: begin
          if (op_muldiv) begin
            state <= T6;
          end else begin
            instr_count <= instr_count + CNT_W'(1);
            state       <= Stop ? HALTED : T0;
          end
        end
        T6: begin
          instr_count <= instr_count + CNT_W'(1);
          state       <= Stop ? HALTED : T0;
        end
        HALTED:  if (Start) state <= T0;
        default: state <= RST;
      endcase
    end
  end

  logic [3:0] rout_sel;
  logic       rout_en;
  logic       rin_en;

  // PCin in T1 follows mem_ready so the PC is written only on the exit cycle.
  always_comb begin
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    operation = 5'b0;
    Run       = 1'b0;
    illegal   = 1'b0;
    rout_sel  = rb;
    rout_en   = 1'b0;
    rin_en    = 1'b0;
    case (state)
      T0: begin
        Run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = mem_ready;
      end
      T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Run = 1'b1;
        if (op_exec) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
        end else if (!op_nop && !op_halt) begin
          illegal = 1'b1;
        end
      end
      T4: begin
        Run       = 1'b1;
        rout_sel  = rc;
        rout_en   = 1'b1;
        Zin       = 1'b1;
        operation = opc;
      end
      T5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        if (op_muldiv) LOin   = 1'b1;
        else           rin_en = 1'b1;
      end
      T6: begin
        Run      = 1'b1;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_onehot_dec u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_onehot_dec u_rin_dec (
    .sel    (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a per-instruction cycle schedule
// built from opcode class is compared against all outputs every cycle.
module tb_control_sequencer;

  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic [31:0]   IR;
  logic          mem_ready;
  logic          Stop;
  logic          Start;
  logic          PCout, Zlowout, Zhighout, MDRout;
  logic          MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic          IncPC, Read, Run, illegal;
  logic [15:0]   Rout, Rin;
  logic [4:0]    operation;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  control_sequencer #(.CNT_W(CW)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .IR          (IR),
    .mem_ready   (mem_ready),
    .Stop        (Stop),
    .Start       (Start),
    .PCout       (PCout),
    .Zlowout     (Zlowout),
    .Zhighout    (Zhighout),
    .MDRout      (MDRout),
    .MARin       (MARin),
    .PCin        (PCin),
    .MDRin       (MDRin),
    .IRin        (IRin),
    .Yin         (Yin),
    .Zin         (Zin),
    .HIin        (HIin),
    .LOin        (LOin),
    .IncPC       (IncPC),
    .Read        (Read),
    .Rout        (Rout),
    .Rin         (Rin),
    .operation   (operation),
    .Run         (Run),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 Clock = ~Clock;

  logic [52:0] obs;
  assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
                Yin, Zin, HIin, LOin, IncPC, Read, Run, illegal,
                operation, Rout, Rin};

  localparam logic [52:0] M_PCOUT    = 53'd1 << 52;
  localparam logic [52:0] M_ZLOWOUT  = 53'd1 << 51;
  localparam logic [52:0] M_ZHIGHOUT = 53'd1 << 50;
  localparam logic [52:0] M_MDROUT   = 53'd1 << 49;
  localparam logic [52:0] M_MARIN    = 53'd1 << 48;
  localparam logic [52:0] M_PCIN     = 53'd1 << 47;
  localparam logic [52:0] M_MDRIN    = 53'd1 << 46;
  localparam logic [52:0] M_IRIN     = 53'd1 << 45;
  localparam logic [52:0] M_YIN      = 53'd1 << 44;
  localparam logic [52:0] M_ZIN      = 53'd1 << 43;
  localparam logic [52:0] M_HIIN     = 53'd1 << 42;
  localparam logic [52:0] M_LOIN     = 53'd1 << 41;
  localparam logic [52:0] M_INCPC    = 53'd1 << 40;
  localparam logic [52:0] M_READ     = 53'd1 << 39;
  localparam logic [52:0] M_RUN      = 53'd1 << 38;
  localparam logic [52:0] M_ILLEGAL  = 53'd1 << 37;

  function automatic logic [CW-1:0] exp_count();
    logic [31:0] c;
    c = model_count;
    return c[CW-1:0];
  endfunction

  function automatic logic [4:0] random_illegal_op();
    logic [4:0] op;
    do op = 5'($urandom_range(0, 31));
    while (op <= 5'd11 || op == 5'd15 || op == 5'd16 || op == 5'd26 || op == 5'd27);
    return op;
  endfunction

  // Runs one instruction, checking every cycle; abort_at drops Resetn mid-cycle.
  task automatic run_instr(input string name, input logic [31:0] ir, input int waits,
                           input int stop_from, input int abort_at, output bit ended_halted);
    logic [52:0] sched[$];
    logic [4:0]  op;
    logic [15:0] oha, ohb, ohc;
    bit          alu, md, aborted;
    int          exec_start;
    op  = ir[31:27];
    oha = 16'h1 << ir[26:23];
    ohb = 16'h1 << ir[22:19];
    ohc = 16'h1 << ir[18:15];
    alu = (op <= 5'd11);
    md  = (op == 5'd15) || (op == 5'd16);
    sched.push_back(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    for (int w = 0; w < waits; w++) sched.push_back(M_RUN | M_ZLOWOUT | M_READ | M_MDRIN);
    sched.push_back(M_RUN | M_ZLOWOUT | M_READ | M_MDRIN | M_PCIN);
    sched.push_back(M_RUN | M_MDROUT | M_IRIN);
    if (alu || md) begin
      sched.push_back(M_RUN | M_YIN | (53'(ohb) << 16));
      sched.push_back(M_RUN | M_ZIN | (53'(op) << 32) | (53'(ohc) << 16));
      if (alu) begin
        sched.push_back(M_RUN | M_ZLOWOUT | 53'(oha));
      end else begin
        sched.push_back(M_RUN | M_ZLOWOUT | M_LOIN);
        sched.push_back(M_RUN | M_ZHIGHOUT | M_HIIN);
      end
    end else if (op == 5'd26 || op == 5'd27) begin
      sched.push_back(M_RUN);
    end else begin
      sched.push_back(M_RUN | M_ILLEGAL);
    end
    exec_start   = 3 + waits;
    aborted      = 1'b0;
    ended_halted = 1'b0;
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge Clock);
      IR        = (i >= exec_start) ? ir : $urandom;
      if (i >= 1 && i <= waits) mem_ready = 1'b0;
      else if (i == waits + 1)  mem_ready = 1'b1;
      else                      mem_ready = 1'($urandom_range(0, 1));
      Stop      = (stop_from >= 0) && (i >= stop_from);
      Start     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== sched[i]) begin
        errors++;
        $display("[TB] FAIL %s strobes cycle %0d: got %h expected %h", name, i, obs, sched[i]);
      end
      checks++;
      if (instr_count !== exp_count()) begin
        errors++;
        $display("[TB] FAIL %s count cycle %0d: got %0d expected %0d", name, i, instr_count, exp_count());
      end
      if (i == abort_at) begin
        #2 Resetn = 1'b0;
        #1;
        model_count = 0;
        checks++;
        if (obs !== 53'd0) begin
          errors++;
          $display("[TB] FAIL %s async reset strobes: got %h expected 0", name, obs);
        end
        checks++;
        if (instr_count !== exp_count()) begin
          errors++;
          $display("[TB] FAIL %s async reset count: got %0d expected 0", name, instr_count);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        Start  = 1'b0;
        Stop   = 1'b0;
        #1;
        checks++;
        if (obs !== 53'd0) begin
          errors++;
          $display("[TB] FAIL %s RST after release: got %h expected 0", name, obs);
        end
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      model_count  = (model_count + 1) % (1 << CW);
      ended_halted = (op == 5'd27) || (stop_from >= 0);
    end
  endtask

  task automatic halted_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      Start     = 1'b0;
      Stop      = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      IR        = $urandom;
      #1;
      checks++;
      if (obs !== 53'd0) begin
        errors++;
        $display("[TB] FAIL %s halted strobes cycle %0d: got %h expected 0", name, i, obs);
      end
      checks++;
      if (instr_count !== exp_count()) begin
        errors++;
        $display("[TB] FAIL %s halted count: got %0d expected %0d", name, instr_count, exp_count());
      end
    end
  endtask

  task automatic start_pulse(input string name);
    @(negedge Clock);
    Start = 1'b1;
    Stop  = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (obs !== 53'd0) begin
      errors++;
      $display("[TB] FAIL %s start cycle strobes: got %h expected 0", name, obs);
    end
  endtask

  task automatic test_reset();
    Resetn    = 1'b0;
    IR        = '0;
    mem_ready = 1'b0;
    Stop      = 1'b0;
    Start     = 1'b0;
    model_count = 0;
    #12;
    checks++;
    if (obs !== 53'd0 || instr_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset: got %h/%0d expected 0/0", obs, instr_count);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
    checks++;
    if (obs !== 53'd0) begin
      errors++;
      $display("[TB] FAIL reset RST cycle: got %h expected 0", obs);
    end
  endtask

  task automatic test_alu();
    bit h;
    run_instr("alu_fixed", 32'h2A2B8000, 0, -1, -1, h);
    for (int k = 0; k < 3; k++)
      run_instr("alu_rand", {5'($urandom_range(0, 11)), 27'($urandom)}, 0, -1, -1, h);
  endtask

  task automatic test_mem_wait();
    bit h;
    run_instr("mem_wait3", {5'($urandom_range(0, 11)), 27'($urandom)}, 3, -1, -1, h);
    run_instr("mem_wait1", {5'b01111, 27'($urandom)}, 1, -1, -1, h);
  endtask

  task automatic test_muldiv();
    bit h;
    run_instr("mul", {5'b01111, 27'($urandom)}, 0, -1, -1, h);
    run_instr("div", {5'b10000, 27'($urandom)}, 2, -1, -1, h);
  endtask

  task automatic test_halt();
    bit h;
    run_instr("halt", {5'b11011, 27'($urandom)}, 0, -1, -1, h);
    halted_idle("halt", 10);
    start_pulse("halt");
    run_instr("after_start", {5'b11010, 27'($urandom)}, 0, -1, -1, h);
  endtask

  task automatic test_stop();
    bit h;
    run_instr("stop_t4", {5'($urandom_range(0, 11)), 27'($urandom)}, 0, 4, -1, h);
    halted_idle("stop", 3);
    start_pulse("stop");
    run_instr("after_stop", {5'($urandom_range(0, 11)), 27'($urandom)}, 0, -1, -1, h);
  endtask

  task automatic test_illegal();
    bit h;
    run_instr("illegal_1f", {5'b11111, 27'($urandom)}, 0, -1, -1, h);
    run_instr("illegal_rand", {random_illegal_op(), 27'($urandom)}, 1, -1, -1, h);
  endtask

  task automatic test_back_to_back();
    bit         h;
    int         waits, stop_from;
    logic [4:0] op;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 5))
        0, 1:    op = 5'($urandom_range(0, 11));
        2:       op = $urandom_range(0, 1) ? 5'b01111 : 5'b10000;
        3:       op = 5'b11010;
        4:       op = ($urandom_range(0, 3) == 0) ? 5'b11011 : 5'b11010;
        default: op = random_illegal_op();
      endcase
      waits     = $urandom_range(0, 3);
      stop_from = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3 + waits) : -1;
      run_instr("random", {op, 27'($urandom)}, waits, stop_from, -1, h);
      if (h) begin
        halted_idle("random", $urandom_range(1, 3));
        start_pulse("random");
      end
    end
  endtask

  task automatic test_reset_mid();
    bit h;
    run_instr("reset_mid", {5'($urandom_range(0, 11)), 27'($urandom)}, 1, -1, 5, h);
    run_instr("post_reset", 32'h2A2B8000, 0, -1, -1, h);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_muldiv();
    test_halt();
    test_stop();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
